// File: rtl/olink_pkg.sv
// Shared link constants for the olink transmit framer and its receive-side counterpart.
package olink_pkg;

    localparam logic [7:0]  K_COMMA    = 8'hBC;
    localparam logic [7:0]  K_IDLE     = 8'hF7;
    localparam logic [7:0]  K_PAD      = 8'h1C;
    localparam logic [7:0]  D_COMMA_HI = 8'h50;

    localparam logic [31:0] IDLE_WORD  = {K_IDLE, K_IDLE, K_IDLE, K_IDLE};
    localparam logic [3:0]  IDLE_K     = 4'b1111;
    // Comma sits in the low half so the far end realigns on the k==01 half-word.
    localparam logic [31:0] COMMA_WORD = {K_IDLE, K_IDLE, D_COMMA_HI, K_COMMA};
    localparam logic [3:0]  COMMA_K    = 4'b1101;

    typedef enum logic {
        PH_LO = 1'b0,
        PH_HI = 1'b1
    } ph_e;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_COMMA = 2'd1,
        SLOT_DATA  = 2'd2,
        SLOT_BADK  = 2'd3
    } slot_kind_e;

    function automatic logic k_pattern_legal(input logic [3:0] k);
        return (k == 4'b0000) || (k == 4'b1111);
    endfunction

    function automatic logic is_k_char(input logic [7:0] b);
        return (b == K_COMMA) || (b == K_IDLE) || (b == K_PAD);
    endfunction

endpackage

// File: rtl/olink_tx_framer.sv
// Transmit framer: serialises 32-bit user words as two 16-bit half-words with
// periodic commas, idle fill, and sent/rejected word counters.
module olink_tx_framer
    import olink_pkg::*;
#(
    parameter int unsigned COMMA_INTERVAL = 256
) (
    input  logic        clk_link,
    input  logic        reset_n,
    input  logic [31:0] tx_word,
    input  logic [3:0]  tx_word_k,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic        force_align,
    input  logic        counter_reset,
    output logic [15:0] tx_d,
    output logic [1:0]  tx_k,
    output logic [31:0] words_sent,
    output logic [15:0] bad_k_count
);

    localparam logic [15:0] SLOT_LAST = 16'(COMMA_INTERVAL - 32'd1);

    ph_e         ph_q, ph_d;
    logic [15:0] slot_q, slot_d;
    logic        rdy_q, rdy_d;
    logic [15:0] hi_word_q, hi_word_d;
    logic [1:0]  hi_k_q, hi_k_d;
    logic [15:0] tx_d_q, tx_d_d;
    logic [1:0]  tx_k_q, tx_k_d;
    logic [31:0] ws_q, ws_d, ws_inc_s;
    logic [15:0] bad_k_q, bad_k_d, bad_k_inc_s;

    slot_kind_e  kind_s;
    logic [31:0] sel_word_s;
    logic [3:0]  sel_k_s;
    logic        comma_due_s;

    assign comma_due_s = (slot_q == 16'd0) || force_align;

    // Slot content selection: comma beats data, data beats idle.
    always_comb begin
        kind_s     = SLOT_IDLE;
        sel_word_s = IDLE_WORD;
        sel_k_s    = IDLE_K;
        if (comma_due_s) begin
            kind_s     = SLOT_COMMA;
            sel_word_s = COMMA_WORD;
            sel_k_s    = COMMA_K;
        end else if (tx_valid) begin
            if (k_pattern_legal(tx_word_k)) begin
                kind_s     = SLOT_DATA;
                sel_word_s = tx_word;
                sel_k_s    = tx_word_k;
            end else begin
                kind_s     = SLOT_BADK;
                sel_word_s = IDLE_WORD;
                sel_k_s    = IDLE_K;
            end
        end else begin
            kind_s     = SLOT_IDLE;
            sel_word_s = IDLE_WORD;
            sel_k_s    = IDLE_K;
        end
    end

    // Next-state for phase, slot counter, half-word pipeline and counters.
    always_comb begin
        ph_d        = (ph_q == PH_LO) ? PH_HI : PH_LO;
        slot_d      = slot_q;
        hi_word_d   = hi_word_q;
        hi_k_d      = hi_k_q;
        tx_d_d      = tx_d_q;
        tx_k_d      = tx_k_q;
        ws_inc_s    = ws_q;
        bad_k_inc_s = bad_k_q;
        // Ready is only ever high in the low-half cycle of a non-comma slot.
        rdy_d       = (ph_q == PH_HI) && (slot_q != 16'd0);
        case (ph_q)
            PH_LO: begin
                slot_d    = (slot_q >= SLOT_LAST) ? 16'd0 : slot_q + 16'd1;
                tx_d_d    = sel_word_s[15:0];
                tx_k_d    = sel_k_s[1:0];
                hi_word_d = sel_word_s[31:16];
                hi_k_d    = sel_k_s[3:2];
                if (kind_s == SLOT_DATA) begin
                    ws_inc_s = ws_q + 32'd1;
                end else if ((kind_s == SLOT_BADK) && (bad_k_q != 16'hFFFF)) begin
                    bad_k_inc_s = bad_k_q + 16'd1;
                end else begin
                    ws_inc_s    = ws_q;
                    bad_k_inc_s = bad_k_q;
                end
            end
            PH_HI: begin
                tx_d_d = hi_word_q;
                tx_k_d = hi_k_q;
            end
            default: begin
                tx_d_d = IDLE_WORD[15:0];
                tx_k_d = IDLE_K[1:0];
            end
        endcase
        ws_d    = counter_reset ? 32'd0 : ws_inc_s;
        bad_k_d = counter_reset ? 16'd0 : bad_k_inc_s;
    end

    // Framer state and registered outputs; reset abandons any slot in flight.
    always_ff @(posedge clk_link or negedge reset_n) begin
        if (!reset_n) begin
            ph_q      <= PH_LO;
            slot_q    <= 16'd0;
            rdy_q     <= 1'b0;
            hi_word_q <= IDLE_WORD[31:16];
            hi_k_q    <= IDLE_K[3:2];
            tx_d_q    <= IDLE_WORD[15:0];
            tx_k_q    <= IDLE_K[1:0];
            ws_q      <= 32'd0;
            bad_k_q   <= 16'd0;
        end else begin
            ph_q      <= ph_d;
            slot_q    <= slot_d;
            rdy_q     <= rdy_d;
            hi_word_q <= hi_word_d;
            hi_k_q    <= hi_k_d;
            tx_d_q    <= tx_d_d;
            tx_k_q    <= tx_k_d;
            ws_q      <= ws_d;
            bad_k_q   <= bad_k_d;
        end
    end

    assign tx_ready    = rdy_q & ~force_align;
    assign tx_d        = tx_d_q;
    assign tx_k        = tx_k_q;
    assign words_sent  = ws_q;
    assign bad_k_count = bad_k_q;

endmodule

// File: tb/tb_olink_tx_framer.sv
// Self-checking bench for olink_tx_framer: vector table plus scoreboarded slot sequences.
module tb_olink_tx_framer;

    logic        clk_link = 1'b0;
    logic        reset_n;
    logic [31:0] tx_word;
    logic [3:0]  tx_word_k;
    logic        tx_valid;
    logic        force_align;
    logic        counter_reset;

    logic        tx_ready4, tx_ready256;
    logic [15:0] tx_d4, tx_d256;
    logic [1:0]  tx_k4, tx_k256;
    logic [31:0] ws4, ws256;
    logic [15:0] bk4, bk256;

    always #5 clk_link = ~clk_link;

    olink_tx_framer #(.COMMA_INTERVAL(4)) dut4 (
        .clk_link(clk_link), .reset_n(reset_n), .tx_word(tx_word), .tx_word_k(tx_word_k),
        .tx_valid(tx_valid), .tx_ready(tx_ready4), .force_align(force_align),
        .counter_reset(counter_reset), .tx_d(tx_d4), .tx_k(tx_k4),
        .words_sent(ws4), .bad_k_count(bk4)
    );

    olink_tx_framer dut256 (
        .clk_link(clk_link), .reset_n(reset_n), .tx_word(tx_word), .tx_word_k(tx_word_k),
        .tx_valid(tx_valid), .tx_ready(tx_ready256), .force_align(force_align),
        .counter_reset(counter_reset), .tx_d(tx_d256), .tx_k(tx_k256),
        .words_sent(ws256), .bad_k_count(bk256)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] d;
        logic [1:0]  k;
        string       nm;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic        v;
        logic [31:0] w;
        logic [3:0]  k;
        logic        fa;
        logic        rdy;
        logic [15:0] lo;
        logic [1:0]  klo;
        logic [15:0] hi;
        logic [1:0]  khi;
        logic [31:0] ws;
        logic [15:0] bk;
    } vec_t;
    vec_t tbl[12];

    int          m_slot;
    logic [31:0] m_ws;
    logic [15:0] m_bk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic sb_pop();
        sb_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_empty: got no expected entry, required one");
        end else begin
            e = sb_q.pop_front();
            chk({e.nm, " d"}, {16'd0, tx_d4}, {16'd0, e.d});
            chk({e.nm, " k"}, {30'd0, tx_k4}, {30'd0, e.k});
        end
    endtask

    // Entered on a negedge that precedes a low-half (ph==0) edge.
    task automatic run_slot(input logic v, input logic [31:0] w, input logic [3:0] k,
                            input logic fa, input logic cr, input logic er,
                            input logic [15:0] elo, input logic [1:0] eklo,
                            input logic [15:0] ehi, input logic [1:0] ekhi, input string nm);
        sb_t e;
        tx_valid = v; tx_word = w; tx_word_k = k; force_align = fa; counter_reset = cr;
        #1;
        chk({nm, " rdy"}, {31'd0, tx_ready4}, {31'd0, er});
        e.d = elo; e.k = eklo; e.nm = {nm, " lo"}; sb_q.push_back(e);
        e.d = ehi; e.k = ekhi; e.nm = {nm, " hi"}; sb_q.push_back(e);
        @(negedge clk_link);
        tx_valid = 1'b0; counter_reset = 1'b0;
        sb_pop();
        @(negedge clk_link);
        sb_pop();
    endtask

    task automatic mslot(input logic v, input logic [31:0] w, input logic [3:0] k,
                         input logic fa, input logic cr, input string nm);
        logic        comma;
        logic [31:0] ew;
        logic [3:0]  ek;
        comma = (m_slot == 0) || fa;
        ew = 32'hF7F7F7F7; ek = 4'b1111;
        if (comma) begin
            ew = 32'hF7F750BC; ek = 4'b1101;
        end else if (v && (k == 4'h0 || k == 4'hF)) begin
            ew = w; ek = k; m_ws = m_ws + 32'd1;
        end else if (v) begin
            if (m_bk != 16'hFFFF) m_bk = m_bk + 16'd1;
        end
        if (cr) begin
            m_ws = 32'd0; m_bk = 16'd0;
        end
        run_slot(v, w, k, fa, cr, !comma, ew[15:0], ek[1:0], ew[31:16], ek[3:2], nm);
        m_slot = (m_slot + 1) % 4;
        chk({nm, " ws"}, ws4, m_ws);
        chk({nm, " bk"}, {16'd0, bk4}, {16'd0, m_bk});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 32'h11112222, 4'h0, 1'b0, 1'b0, 16'h50BC, 2'b01, 16'hF7F7, 2'b11, 32'd0, 16'd0};
        tbl[1]  = '{1'b1, 32'h11112222, 4'h0, 1'b0, 1'b1, 16'h2222, 2'b00, 16'h1111, 2'b00, 32'd1, 16'd0};
        tbl[2]  = '{1'b1, 32'hA5A55A5A, 4'hF, 1'b0, 1'b1, 16'h5A5A, 2'b11, 16'hA5A5, 2'b11, 32'd2, 16'd0};
        tbl[3]  = '{1'b0, 32'h00000000, 4'h0, 1'b0, 1'b1, 16'hF7F7, 2'b11, 16'hF7F7, 2'b11, 32'd2, 16'd0};
        tbl[4]  = '{1'b1, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0, 16'h50BC, 2'b01, 16'hF7F7, 2'b11, 32'd2, 16'd0};
        tbl[5]  = '{1'b1, 32'hDEADBEEF, 4'h0, 1'b0, 1'b1, 16'hBEEF, 2'b00, 16'hDEAD, 2'b00, 32'd3, 16'd0};
        tbl[6]  = '{1'b1, 32'h12345678, 4'h5, 1'b0, 1'b1, 16'hF7F7, 2'b11, 16'hF7F7, 2'b11, 32'd3, 16'd1};
        tbl[7]  = '{1'b1, 32'hCAFEF00D, 4'h0, 1'b1, 1'b0, 16'h50BC, 2'b01, 16'hF7F7, 2'b11, 32'd3, 16'd1};
        tbl[8]  = '{1'b0, 32'h00000000, 4'h0, 1'b0, 1'b0, 16'h50BC, 2'b01, 16'hF7F7, 2'b11, 32'd3, 16'd1};
        tbl[9]  = '{1'b1, 32'h0BADF00D, 4'h3, 1'b0, 1'b1, 16'hF7F7, 2'b11, 16'hF7F7, 2'b11, 32'd3, 16'd2};
        tbl[10] = '{1'b1, 32'h00000000, 4'h0, 1'b0, 1'b1, 16'h0000, 2'b00, 16'h0000, 2'b00, 32'd4, 16'd2};
        tbl[11] = '{1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 1'b1, 16'hFFFF, 2'b11, 16'hFFFF, 2'b11, 32'd5, 16'd2};

        reset_n = 1'b0; tx_word = 32'd0; tx_word_k = 4'd0; tx_valid = 1'b0;
        force_align = 1'b0; counter_reset = 1'b0;
        repeat (2) @(negedge clk_link);
        chk("rst tx_d", {16'd0, tx_d4}, 32'h0000F7F7);
        chk("rst tx_k", {30'd0, tx_k4}, 32'd3);
        chk("rst ready", {31'd0, tx_ready4}, 32'd0);
        chk("rst ws", ws4, 32'd0);
        chk("rst bk", {16'd0, bk4}, 32'd0);
        chk("rst ws256", ws256, 32'd0);
        chk("rst bk256", {16'd0, bk256}, 32'd0);
        reset_n = 1'b1;

        // Idle link on the default-interval instance: comma only at slots 0 and 256.
        for (int s = 0; s <= 256; s++) begin
            #1;
            chk($sformatf("p1 s%0d rdy", s), {31'd0, tx_ready256}, (s % 256 == 0) ? 32'd0 : 32'd1);
            @(negedge clk_link);
            chk($sformatf("p1 s%0d lo", s), {14'd0, tx_k256, tx_d256},
                (s % 256 == 0) ? 32'h000150BC : 32'h0003F7F7);
            @(negedge clk_link);
            chk($sformatf("p1 s%0d hi", s), {14'd0, tx_k256, tx_d256}, 32'h0003F7F7);
        end

        reset_n = 1'b0;
        @(negedge clk_link);
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            run_slot(tbl[i].v, tbl[i].w, tbl[i].k, tbl[i].fa, 1'b0, tbl[i].rdy,
                     tbl[i].lo, tbl[i].klo, tbl[i].hi, tbl[i].khi, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d ws", i), ws4, tbl[i].ws);
            chk($sformatf("tbl%0d bk", i), {16'd0, bk4}, {16'd0, tbl[i].bk});
        end
        m_slot = 0; m_ws = 32'd5; m_bk = 16'd2;

        for (int i = 0; i < 8; i++) mslot(1'b1, 32'h11112222, 4'h0, 1'b0, 1'b0, $sformatf("cont%0d", i));
        for (int i = 0; i < 10; i++) mslot(1'b1, 32'hCAFEBABE, 4'h0, 1'b1, 1'b0, $sformatf("fa%0d", i));
        for (int i = 0; i < 4; i++) mslot(1'b1, 32'h0F0F1E1E, 4'h0, 1'b0, 1'b0, $sformatf("postfa%0d", i));
        mslot(1'b1, 32'h13572468, 4'h0, 1'b0, 1'b1, "crsend");
        mslot(1'b1, 32'h24681357, 4'h0, 1'b0, 1'b0, "aftercr");

        force dut4.bad_k_q = 16'hFFFF;
        #1;
        release dut4.bad_k_q;
        chk("sat preload", {16'd0, bk4}, 32'h0000FFFF);
        m_bk = 16'hFFFF;
        mslot(1'b0, 32'd0, 4'h0, 1'b0, 1'b0, "satcomma");
        mslot(1'b1, 32'h12345678, 4'h8, 1'b0, 1'b0, "satbad");

        // Reset while the high half of a data word is on the wire.
        tx_valid = 1'b1; tx_word = 32'h89ABCDEF; tx_word_k = 4'h0;
        @(negedge clk_link);
        tx_valid = 1'b0;
        chk("mid lo", {14'd0, tx_k4, tx_d4}, 32'h0000CDEF);
        @(negedge clk_link);
        chk("mid hi", {14'd0, tx_k4, tx_d4}, 32'h000089AB);
        chk("mid ws", ws4, 32'd2);
        reset_n = 1'b0;
        #1;
        chk("midrst tx", {14'd0, tx_k4, tx_d4}, 32'h0003F7F7);
        chk("midrst rdy", {31'd0, tx_ready4}, 32'd0);
        chk("midrst ws", ws4, 32'd0);
        @(negedge clk_link);
        reset_n = 1'b1;
        m_slot = 0; m_ws = 32'd0; m_bk = 16'd0;
        mslot(1'b1, 32'h55667788, 4'h0, 1'b0, 1'b0, "postrst0");
        mslot(1'b1, 32'h55667788, 4'h0, 1'b0, 1'b0, "postrst1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/olink_tx_framer.md
OLINK_TX_FRAMER -- requirements
Module: olink_tx_framer

Interface
REQ-001 SHALL have parameter COMMA_INTERVAL, default 256, number of 32-bit word slots per comma; legal range 2..65535.
REQ-002 SHALL have ports:
- clk_link  in  1  link word clock; one clock only.
- reset_n  in  1  reset, asynchronous, active-low.
- tx_word  in  32  user word.
- tx_word_k  in  4  per-byte K flags for tx_word.
- tx_valid  in  1  tx_word valid.
- tx_ready  out  1  word accepted when tx_valid && tx_ready at a rising edge.
- force_align  in  1  while high, every slot carries a comma word.
- counter_reset  in  1  synchronous clear of both counters.
- tx_d  out  16  half-word to transceiver txdata.
- tx_k  out  2  K flags to transceiver txcharisk.
- words_sent  out  32  data words transmitted.
- bad_k_count  out  16  words rejected for illegal K pattern.

Function
REQ-003 SHALL keep a phase bit ph, toggling on every clk_link edge; a word slot is two cycles: low half (bits 15:0, k 1:0), then high half (bits 31:16, k 3:2).
REQ-004 SHALL, at each edge where ph==0, select the slot's word with priority comma > data > idle, register it, and drive its low half on tx_d/tx_k after that edge.
REQ-005 SHALL, at each edge where ph==1, drive the high half of the registered word.
REQ-006 Comma word: low half 16'h50BC, k 2'b01; high half 16'hF7F7, k 2'b11.
REQ-007 Idle word: 32'hF7F7F7F7, k 4'b1111.
REQ-008 tx_ready SHALL be a function of state only (not tx_valid): high iff ph==0, no comma due, force_align low.
REQ-009 Latency: an accepted word's low half SHALL appear on tx_d the cycle after acceptance, high half the cycle after that; no other buffering.
REQ-010 Accepted word with tx_word_k 4'b0000 or 4'b1111 SHALL be sent unchanged; any other tx_word_k SHALL send the idle word instead and increment bad_k_count.
REQ-011 Slot counter SHALL count slots modulo COMMA_INTERVAL; the slot where it equals 0 SHALL be a comma slot; the counter keeps running while force_align is high.
REQ-012 No valid word in a non-comma slot (tx_valid low at the ph==0 edge) SHALL send idle.
REQ-013 words_sent SHALL increment once per data word sent with unchanged K (both legal K patterns), wrapping 32'hFFFFFFFF->0.
REQ-014 bad_k_count SHALL saturate at 16'hFFFF.
REQ-015 counter_reset SHALL clear both counters on the next edge and take precedence over a simultaneous increment.
REQ-016 A comma slot SHALL always start on a ph==0 cycle, so the far-end receiver (comma at k==01 resets its pairing phase) realigns.

Reset
REQ-017 While reset_n is low: ph=0, slot counter=0 (first slot after release is a comma), tx_d=16'hF7F7, tx_k=2'b11, tx_ready=0, words_sent=0, bad_k_count=0.
REQ-018 Reset asserted mid-slot SHALL abandon the slot immediately; the abandoned word is not counted.

Structure
REQ-019 SHALL place constants K_COMMA 8'hBC, K_IDLE 8'hF7, K_PAD 8'h1C, D_COMMA_HI 8'h50 and the idle and comma word values in shared package olink_pkg, reused by the receive side.
REQ-020 SHALL be a single module with no sub-modules; counters are inline.

Verification
REQ-021 Release reset, tx_valid=0 -> slot 0: 50BC/01, F7F7/11; then F7F7/11 repeated; comma repeats every 256 slots (512 cycles).
REQ-022 COMMA_INTERVAL=4, tx_valid=1 continuous, words 0x11112222, k=0 -> 2222/00, 1111/00; tx_ready low on each comma slot; words_sent +3 per 4 slots.
REQ-023 Accept word with tx_word_k=4'b0101 -> idle word sent, bad_k_count=1, words_sent unchanged.
REQ-024 force_align=1 for 10 slots with tx_valid=1 -> 10 comma words, tx_ready=0 throughout, no words consumed; after drop, comma positions unchanged.
REQ-025 counter_reset in the same cycle as a data send -> words_sent=0 next cycle; preload bad_k_count to 16'hFFFF, one more bad word -> stays 16'hFFFF.
REQ-026 Assert reset_n=0 during the high-half cycle of a data word -> outputs F7F7/11 immediately; after release, first slot is a comma; words_sent=0.
